// File: rtl/fetch_unit.sv
// WISC instruction-fetch front end: owns the PC, prefetches over req/ack
// into a small instruction buffer, handles branch redirects and HLT.
module fetch_unit #(
    parameter int unsigned         ADDR_W     = 16,
    parameter int unsigned         INSTR_W    = 16,
    parameter int unsigned         DEPTH      = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
    parameter logic [3:0]          HLT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_plus2,
    input  logic               id_ready,
    output logic               hlt,
    output logic [ADDR_W-1:0]  pc
);

    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_HALTED
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [CNT_W-1:0]   count_q, count_d, count_nx;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               halt_pend_q, halt_pend_d;
    logic               hlt_q, hlt_d;

    logic [ADDR_W-1:0]  buf_pc_q    [DEPTH];
    logic [INSTR_W-1:0] buf_instr_q [DEPTH];

    logic busy, ack, pop, pop_hlt, redir, push;

    assign busy        = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign ack         = imem_ack && busy;
    assign imem_req    = busy;
    assign imem_addr   = (state_q == S_DRAIN) ? req_addr_q : fetch_pc_q;
    assign id_valid    = (count_q != '0) && (state_q != S_HALTED);
    assign id_pc       = buf_pc_q[rd_ptr_q];
    assign id_instr    = buf_instr_q[rd_ptr_q];
    assign id_pc_plus2 = id_pc + ADDR_W'(2);
    assign pop         = id_valid && id_ready;
    assign pop_hlt     = pop && (id_instr[INSTR_W-1 -: 4] == HLT_OPCODE);
    assign redir       = redirect_valid && (state_q != S_HALTED);
    assign hlt         = hlt_q;
    // Once halted the head still holds the HLT word, so pc freezes on it.
    assign pc = (id_valid || state_q == S_HALTED) ? id_pc : fetch_pc_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        halt_pend_d = halt_pend_q;
        hlt_d       = hlt_q;
        req_addr_d  = (state_q == S_WAIT) ? fetch_pc_q : req_addr_q;
        push        = 1'b0;
        count_nx    = count_q;
        priority case (1'b1)
            (state_q == S_HALTED): begin
            end
            redir: begin
                fetch_pc_d  = redirect_pc & ~ADDR_W'(1);
                halt_pend_d = 1'b0;
                count_d     = '0;
                wr_ptr_d    = rd_ptr_q;
                state_d     = (busy && !imem_ack) ? S_DRAIN : S_IDLE;
            end
            pop_hlt: begin
                hlt_d    = 1'b1;
                state_d  = S_HALTED;
                count_d  = '0;
                wr_ptr_d = rd_ptr_q;
            end
            default: begin
                push     = (state_q == S_WAIT) && imem_ack;
                count_nx = count_q + CNT_W'(push) - CNT_W'(pop);
                count_d  = count_nx;
                rd_ptr_d = rd_ptr_q + PTR_W'(pop);
                unique case (state_q)
                    S_IDLE: begin
                        if (count_nx < FULL && !halt_pend_q)
                            state_d = S_WAIT;
                    end
                    S_WAIT: begin
                        if (push) begin
                            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                            fetch_pc_d = fetch_pc_q + ADDR_W'(2);
                            if (imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE) begin
                                halt_pend_d = 1'b1;
                                state_d     = S_IDLE;
                            end else if (count_nx == FULL) begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (ack)
                            state_d = S_IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            halt_pend_q <= 1'b0;
            hlt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            halt_pend_q <= halt_pend_d;
            hlt_q       <= hlt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= fetch_pc_q;
            buf_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed tables, corner sequences and a randomized
// run checked against a program-order scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus2;
    logic        id_ready = 1'b0;
    logic        hlt;
    logic [15:0] pc;

    int n_cmp = 0;
    int n_err = 0;

    // memory model controls
    int          fixed_lat = 0;
    bit          rand_lat  = 1'b0;
    logic [15:0] hlt_addr  = 16'h0001;
    int          wcnt = 0;
    int          rlat = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus2    (id_pc_plus2),
        .id_ready       (id_ready),
        .hlt            (hlt),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] word(input logic [15:0] a);
        return (a == hlt_addr) ? 16'hF000 : {4'h2, a[12:1]};
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst_n || !imem_req) begin
            wcnt     = 0;
            imem_ack = 1'b0;
        end else if (wcnt >= (rand_lat ? rlat : fixed_lat)) begin
            imem_ack   = 1'b1;
            imem_rdata = word(imem_addr);
            wcnt       = 0;
            rlat       = $urandom_range(0, 3);
        end else begin
            imem_ack = 1'b0;
            wcnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one(output logic [15:0] p, output logic [15:0] ins,
                           output logic [15:0] p2);
        int k = 0;
        while (!id_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!id_valid) begin
            n_err++;
            $display("FAIL pop_timeout: id_valid=0 after %0d cycles, required 1", k);
            p   = '0;
            ins = '0;
            p2  = '0;
        end else begin
            p   = id_pc;
            ins = id_instr;
            p2  = id_pc_plus2;
            id_ready = 1'b1;
            @(negedge clk);
            id_ready = 1'b0;
        end
    endtask

    task automatic redirect_to(input logic [15:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] target;
        logic [15:0] pc0;
        logic [15:0] p2_0;
        logic [15:0] pc1;
    } redir_vec_t;

    redir_vec_t  vecs [5];
    logic [15:0] t1_pc [4];

    initial begin
        logic [15:0] p, ins, p2;
        int acks;
        int k;
        int pops;
        logic [15:0] expect_pc;
        logic prev_req, prev_ack;
        logic [15:0] prev_addr;

        t1_pc   = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
        vecs[0] = '{16'h0041, 16'h0040, 16'h0042, 16'h0042};
        vecs[1] = '{16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000};
        vecs[2] = '{16'h0100, 16'h0100, 16'h0102, 16'h0102};
        vecs[3] = '{16'h7FFF, 16'h7FFE, 16'h8000, 16'h8000};
        vecs[4] = '{16'hFFFD, 16'hFFFC, 16'hFFFE, 16'hFFFE};

        // 1: reset values, fill to full, in-order drain
        rst_n = 1'b0;
        cycles(2);
        check("rst_req", imem_req, 0);
        check("rst_valid", id_valid, 0);
        check("rst_hlt", hlt, 0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_pc", pc, 16'h0000);
        rst_n = 1'b1;
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (imem_req && imem_ack) acks++;
        end
        check("fill_acks", acks, 4);
        check("full_no_req", imem_req, 0);
        check("full_pc", pc, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            pop_one(p, ins, p2);
            check("fill_pc", p, t1_pc[i]);
            check("fill_instr", ins, word(t1_pc[i]));
        end

        // 2: redirect while waiting on 0x0008, slow memory
        fixed_lat = 3;
        do_reset();
        id_ready = 1'b1;
        k = 0;
        while (!(imem_req && imem_addr == 16'h0008 && !imem_ack) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("wait8_reached", imem_addr, 16'h0008);
        id_ready = 1'b0;
        redirect_to(16'h0041);
        check("drain_req", imem_req, 1);
        check("drain_addr", imem_addr, 16'h0008);
        k = 0;
        while ((!imem_req || imem_addr == 16'h0008) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("redir_req_addr", imem_addr, 16'h0040);
        pop_one(p, ins, p2);
        check("redir_first_pc", p, 16'h0040);
        check("redir_first_instr", ins, word(16'h0040));

        // redirect table incl. odd targets and address wrap
        fixed_lat = 0;
        do_reset();
        cycles(8);
        foreach (vecs[i]) begin
            redirect_to(vecs[i].target);
            pop_one(p, ins, p2);
            check("tbl_pc0", p, vecs[i].pc0);
            check("tbl_instr0", ins, word(vecs[i].pc0));
            check("tbl_plus2", p2, vecs[i].p2_0);
            pop_one(p, ins, p2);
            check("tbl_pc1", p, vecs[i].pc1);
            cycles(3);
        end

        // 3: HLT at 0x000A stops fetch and halts once consumed
        hlt_addr = 16'h000A;
        do_reset();
        cycles(8);
        for (int i = 0; i < 5; i++) begin
            pop_one(p, ins, p2);
            check("hlt_seq_pc", p, 16'(2 * i));
        end
        cycles(3);
        check("hlt_pend_no_req", imem_req, 0);
        check("hlt_head_pc", id_pc, 16'h000A);
        check("hlt_before", hlt, 0);
        pop_one(p, ins, p2);
        check("hlt_instr", ins, 16'hF000);
        check("hlt_set", hlt, 1);
        check("hlt_pc", pc, 16'h000A);
        check("hlt_valid", id_valid, 0);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) redirect_to(16'h0200);
            else @(negedge clk);
            if (imem_req) acks++;
        end
        check("halted_reqs", acks, 0);
        check("halted_hlt", hlt, 1);
        check("halted_pc", pc, 16'h000A);

        // 4: buffered HLT cancelled by redirect
        do_reset();
        cycles(8);
        for (int i = 0; i < 4; i++) pop_one(p, ins, p2);
        cycles(4);
        check("pend_no_req", imem_req, 0);
        check("pend_head", id_pc, 16'h0008);
        redirect_to(16'h0100);
        pop_one(p, ins, p2);
        check("cancel_pc", p, 16'h0100);
        check("cancel_hlt", hlt, 0);
        pop_one(p, ins, p2);
        check("cancel_pc2", p, 16'h0102);
        hlt_addr = 16'h0001;

        // 6: reset while a request is pending
        fixed_lat = 3;
        do_reset();
        k = 0;
        while (!imem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pre_rst_req", imem_req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_valid", id_valid, 0);
        check("mid_rst_addr", imem_addr, 16'h0000);
        check("mid_rst_pc", pc, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!imem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("post_rst_addr", imem_addr, 16'h0000);
        pop_one(p, ins, p2);
        check("post_rst_pc", p, 16'h0000);

        // randomized run against a program-order scoreboard
        rand_lat = 1'b1;
        do_reset();
        expect_pc = 16'h0000;
        pops      = 0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
        for (int c = 0; c < 2000; c++) begin
            logic rv, rdy;
            logic [15:0] tgt;
            if (prev_req && !prev_ack && imem_req)
                check("addr_stable", imem_addr, prev_addr);
            rv  = ($urandom_range(0, 15) == 0);
            rdy = 1'(($urandom_range(0, 3) != 0));
            tgt = 16'($urandom);
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
            id_ready  = rdy;
            if (rv) begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                expect_pc      = tgt & 16'hFFFE;
            end else begin
                redirect_valid = 1'b0;
                if (id_valid && rdy) begin
                    check("rand_pc", id_pc, expect_pc);
                    check("rand_instr", id_instr, word(expect_pc));
                    expect_pc = expect_pc + 16'd2;
                    pops++;
                end
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        check("rand_progress", pops > 200, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
